// File: rtl/is_uart_tx_engine.sv
// UART transmit engine: small push FIFO feeding a bit_ce_i-paced frame serializer.
// Define IS_UART_TX_BREAK_EN to compile in break generation (BREAK state driven by brk_i).
module is_uart_tx_engine #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              bit_ce_i,
    input  logic                              tx_valid_i,
    input  logic [DATA_W-1:0]                 tx_data_i,
    output logic                              tx_ready_o,
    input  logic [1:0]                        par_mode_i,
    input  logic                              stop2_i,
    input  logic                              brk_i,
    output logic                              txd_o,
    output logic                              txct_o,
    output logic                              busy_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
`ifdef IS_UART_TX_BREAK_EN
        , ST_BREAK
`endif
    } state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full, empty, push, pop, frame_end;

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic              txd_q, txct_q, par_en_q, par_bit_q, stop2_q;

    assign full       = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty      = (cnt_q == '0);
    assign tx_ready_o = !full;
    assign push       = tx_valid_i && !full;
    assign fifo_cnt_o = cnt_q;
    assign txd_o      = txd_q;
    assign txct_o     = txct_q;
    assign busy_o     = (state_q != ST_IDLE);

    assign frame_end  = bit_ce_i && ((state_q == ST_STOP1 && !stop2_q) || state_q == ST_STOP2);

`ifdef IS_UART_TX_BREAK_EN
    logic brk_take;
    assign brk_take = bit_ce_i && (state_q == ST_IDLE) && brk_i;
    assign pop      = !empty && !brk_take && ((bit_ce_i && state_q == ST_IDLE) || frame_end);
`else
    logic unused_brk;
    assign unused_brk = brk_i;
    assign pop        = !empty && ((bit_ce_i && state_q == ST_IDLE) || frame_end);
`endif

    // pop only looks at the registered count, so a word written this cycle waits one cycle
    assign cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
            txct_q    <= 1'b1;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else if (bit_ce_i) begin
            if (pop) begin
                // frame configuration is captured together with the word
                state_q   <= ST_START;
                shift_q   <= mem_q[rd_ptr_q];
                par_en_q  <= (par_mode_i == 2'd1) || (par_mode_i == 2'd2);
                par_bit_q <= (^mem_q[rd_ptr_q]) ^ (par_mode_i == 2'd2);
                stop2_q   <= stop2_i;
                txd_q     <= 1'b0;
                txct_q    <= 1'b0;
            end
`ifdef IS_UART_TX_BREAK_EN
            else if (brk_take) begin
                state_q <= ST_BREAK;
                txd_q   <= 1'b0;
                txct_q  <= 1'b0;
            end
`endif
            else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_START: begin
                        txd_q     <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_cnt_q != BIT_W'(DATA_W - 1)) begin
                            shift_q   <= shift_q >> 1;
                            txd_q     <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end else if (par_en_q) begin
                            txd_q   <= par_bit_q;
                            state_q <= ST_PARITY;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP1;
                        end
                    end
                    ST_PARITY: begin
                        txd_q   <= 1'b1;
                        state_q <= ST_STOP1;
                    end
                    ST_STOP1: begin
                        if (stop2_q) begin
                            state_q <= ST_STOP2;
                        end else begin
                            txd_q   <= 1'b1;
                            txct_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_STOP2: begin
                        txd_q   <= 1'b1;
                        txct_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
`ifdef IS_UART_TX_BREAK_EN
                    ST_BREAK: begin
                        if (!brk_i) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP1;
                        end
                    end
`endif
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_is_uart_tx_engine.sv
// Self-checking bench for is_uart_tx_engine: line-level frame model fed by random words/configs.
module tb_is_uart_tx_engine;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_ce = 1'b0;
    logic tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic tx_ready;
    logic [1:0] par_mode = 2'd0;
    logic stop2 = 1'b0;
    logic brk = 1'b0;
    logic txd, txct, busy;
    logic [$clog2(DEPTH+1)-1:0] fifo_cnt;

    int checks = 0;
    int errors = 0;

    bit exp_d[$], exp_c[$], got_d[$], got_c[$], got_e[$];
    bit last_s2 = 1'b0;

    always #5 clk = ~clk;

    is_uart_tx_engine #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .bit_ce_i(bit_ce), .tx_valid_i(tx_valid),
        .tx_data_i(tx_data), .tx_ready_o(tx_ready), .par_mode_i(par_mode),
        .stop2_i(stop2), .brk_i(brk), .txd_o(txd), .txct_o(txct),
        .busy_o(busy), .fifo_cnt_o(fifo_cnt)
    );

    // Expected line: start 0, data LSB first, optional parity, one or two 1 stop bits.
    task automatic model_frame(input logic [DW-1:0] w, input logic [1:0] pm, input logic s2);
        bit p;
        exp_d.push_back(1'b0); exp_c.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            exp_d.push_back(w[i]); exp_c.push_back(1'b0);
        end
        if (pm == 2'd1 || pm == 2'd2) begin
            p = ($countones(w) % 2) == 1;
            if (pm == 2'd2) p = !p;
            exp_d.push_back(p); exp_c.push_back(1'b0);
        end
        exp_d.push_back(1'b1); exp_c.push_back(1'b0);
        if (s2) begin
            exp_d.push_back(1'b1); exp_c.push_back(1'b0);
        end
        last_s2 = s2;
    endtask

    task automatic model_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_d.push_back(1'b1); exp_c.push_back(1'b1);
        end
    endtask

    task automatic clr();
        exp_d.delete(); exp_c.delete(); got_d.delete(); got_c.delete(); got_e.delete();
    endtask

    task automatic push(input logic [DW-1:0] w);
        @(negedge clk); tx_valid = 1'b1; tx_data = w;
        @(negedge clk); tx_valid = 1'b0;
    endtask

    // One bit period of 'gap' clocks: sample right after the strobe and again at period end.
    task automatic tick(input int gap);
        @(negedge clk); bit_ce = 1'b1;
        @(posedge clk); #1;
        got_d.push_back(txd); got_c.push_back(txct);
        @(negedge clk); bit_ce = 1'b0;
        repeat (gap - 2) @(negedge clk);
        got_e.push_back(txd);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", txd); end
        checks++; if (txct !== 1'b1) begin errors++; $display("FAIL reset_txct got %b exp 1", txct); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (fifo_cnt !== 0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", fifo_cnt); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", tx_ready); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: released");
    endtask

    task automatic test_a5();
        logic [0:9] seq;
        seq = 10'b0101001011;
        clr(); par_mode = 2'd0; stop2 = 1'b0; last_s2 = 1'b0;
        push(8'hA5);
        for (int i = 0; i < 12; i++) begin
            tick(16);
            if (i == 0) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL a5_busy got %b exp 1", busy); end
            end
        end
        for (int i = 0; i < 12; i++) begin
            bit ed, ec;
            ed = (i < 10) ? seq[i] : 1'b1;
            ec = (i >= 10);
            checks++; if (got_d[i] !== ed) begin errors++; $display("FAIL a5_txd bit %0d got %b exp %b", i, got_d[i], ed); end
            checks++; if (got_c[i] !== ec) begin errors++; $display("FAIL a5_txct bit %0d got %b exp %b", i, got_c[i], ec); end
            checks++; if (got_e[i] !== ed) begin errors++; $display("FAIL a5_hold bit %0d got %b exp %b", i, got_e[i], ed); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_idle_busy got %b exp 0", busy); end
        $display("a5: frame of 0xA5 checked over 12 bit periods");
    endtask

    task automatic test_parity_stop();
        logic [1:0] pms [4];
        logic       s2s [4];
        pms = '{2'd1, 2'd2, 2'd3, 2'd0};
        s2s = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            clr(); par_mode = pms[k]; stop2 = s2s[k];
            push(8'h07);
            model_frame(8'h07, pms[k], s2s[k]); model_idle(2);
            for (int i = 0; i < exp_d.size(); i++) tick(3);
            for (int i = 0; i < got_d.size(); i++) begin
                checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL par_txd case %0d bit %0d got %b exp %b", k, i, got_d[i], exp_d[i]); end
                checks++; if (got_c[i] !== exp_c[i]) begin errors++; $display("FAIL par_txct case %0d bit %0d got %b exp %b", k, i, got_c[i], exp_c[i]); end
                checks++; if (got_e[i] !== exp_d[i]) begin errors++; $display("FAIL par_hold case %0d bit %0d got %b exp %b", k, i, got_e[i], exp_d[i]); end
            end
            $display("parity: 0x07 mode %0d stop2 %0d, %0d bit periods", pms[k], s2s[k], exp_d.size());
        end
    endtask

    task automatic test_fifo_full();
        logic [DW-1:0] words [5];
        int acc;
        clr(); par_mode = 2'($urandom_range(3)); stop2 = 1'($urandom_range(1)); acc = 0;
        for (int k = 0; k < 5; k++) begin
            words[k] = DW'($urandom);
            push(words[k]);
            if (acc < DEPTH) begin
                model_frame(words[k], par_mode, stop2); acc++;
            end
            checks++; if (fifo_cnt !== acc) begin errors++; $display("FAIL full_cnt push %0d got %0d exp %0d", k, fifo_cnt, acc); end
            checks++; if (tx_ready !== (acc < DEPTH)) begin errors++; $display("FAIL full_ready push %0d got %b exp %b", k, tx_ready, acc < DEPTH); end
        end
        model_idle(2);
        for (int i = 0; i < exp_d.size(); i++) tick(2);
        for (int i = 0; i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL full_txd bit %0d got %b exp %b", i, got_d[i], exp_d[i]); end
            checks++; if (got_c[i] !== exp_c[i]) begin errors++; $display("FAIL full_txct bit %0d got %b exp %b", i, got_c[i], exp_c[i]); end
            checks++; if (got_e[i] !== exp_d[i]) begin errors++; $display("FAIL full_hold bit %0d got %b exp %b", i, got_e[i], exp_d[i]); end
        end
        $display("fifo_full: 5 pushes, 4 accepted frames sent back-to-back");
    endtask

    task automatic test_no_bypass();
        logic [DW-1:0] x, y;
        clr(); x = DW'($urandom); y = DW'($urandom);
        par_mode = 2'($urandom_range(3)); stop2 = 1'($urandom_range(1));
        @(negedge clk); tx_valid = 1'b1; tx_data = x; bit_ce = 1'b1;
        @(posedge clk); #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL bypass_txd got %b exp 1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bypass_busy got %b exp 0", busy); end
        checks++; if (fifo_cnt !== 1) begin errors++; $display("FAIL bypass_cnt got %0d exp 1", fifo_cnt); end
        @(negedge clk); tx_valid = 1'b1; tx_data = y; bit_ce = 1'b1;
        @(posedge clk); #1;
        got_d.push_back(txd); got_c.push_back(txct);
        checks++; if (fifo_cnt !== 1) begin errors++; $display("FAIL pushpop_cnt got %0d exp 1", fifo_cnt); end
        @(negedge clk); tx_valid = 1'b0; bit_ce = 1'b0;
        @(negedge clk); got_e.push_back(txd);
        model_frame(x, par_mode, stop2); model_frame(y, par_mode, stop2); model_idle(2);
        for (int i = 1; i < exp_d.size(); i++) tick(3);
        for (int i = 0; i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL bypass_frame_txd bit %0d got %b exp %b", i, got_d[i], exp_d[i]); end
            checks++; if (got_c[i] !== exp_c[i]) begin errors++; $display("FAIL bypass_frame_txct bit %0d got %b exp %b", i, got_c[i], exp_c[i]); end
            checks++; if (got_e[i] !== exp_d[i]) begin errors++; $display("FAIL bypass_frame_hold bit %0d got %b exp %b", i, got_e[i], exp_d[i]); end
        end
        $display("no_bypass: words %h %h, simultaneous push/pop held count", x, y);
    endtask

    task automatic test_cfg_change();
        logic [DW-1:0] w1, w2;
        logic [1:0] pa, pb;
        logic sa, sb;
        clr(); w1 = DW'($urandom); w2 = DW'($urandom);
        pa = 2'($urandom_range(3)); sa = 1'($urandom_range(1));
        pb = pa + 2'd1; sb = !sa;
        par_mode = pa; stop2 = sa;
        push(w1); push(w2);
        model_frame(w1, pa, sa); model_frame(w2, pb, sb); model_idle(2);
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i == 3) begin par_mode = pb; stop2 = sb; end
            tick(2);
        end
        for (int i = 0; i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL cfg_txd bit %0d got %b exp %b", i, got_d[i], exp_d[i]); end
            checks++; if (got_c[i] !== exp_c[i]) begin errors++; $display("FAIL cfg_txct bit %0d got %b exp %b", i, got_c[i], exp_c[i]); end
            checks++; if (got_e[i] !== exp_d[i]) begin errors++; $display("FAIL cfg_hold bit %0d got %b exp %b", i, got_e[i], exp_d[i]); end
        end
        $display("cfg_change: mode %0d/%0d stop2 %0d/%0d applied per frame", pa, pb, sa, sb);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w1, w4;
        clr(); w1 = DW'($urandom) & ~DW'(8); w4 = DW'($urandom);
        par_mode = 2'($urandom_range(3)); stop2 = 1'($urandom_range(1));
        push(w1); push(DW'($urandom)); push(DW'($urandom));
        repeat (5) tick(3);
        checks++; if (got_d[4] !== w1[3]) begin errors++; $display("FAIL rstmid_bit3 got %b exp %b", got_d[4], w1[3]); end
        #3 rst = 1'b1;
        #1;
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_txd got %b exp 1", txd); end
        checks++; if (txct !== 1'b1) begin errors++; $display("FAIL rstmid_txct got %b exp 1", txct); end
        checks++; if (fifo_cnt !== 0) begin errors++; $display("FAIL rstmid_cnt got %0d exp 0", fifo_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0; last_s2 = 1'b0;
        clr();
        push(w4);
        model_frame(w4, par_mode, stop2); model_idle(2);
        for (int i = 0; i < exp_d.size(); i++) tick(4);
        for (int i = 0; i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL rstmid_txd bit %0d got %b exp %b", i, got_d[i], exp_d[i]); end
            checks++; if (got_c[i] !== exp_c[i]) begin errors++; $display("FAIL rstmid_txct bit %0d got %b exp %b", i, got_c[i], exp_c[i]); end
            checks++; if (got_e[i] !== exp_d[i]) begin errors++; $display("FAIL rstmid_hold bit %0d got %b exp %b", i, got_e[i], exp_d[i]); end
        end
        $display("reset_mid: frame aborted at data bit 3, next frame %h checked", w4);
    endtask

    task automatic test_break();
        logic [DW-1:0] w;
        clr(); w = DW'($urandom);
        par_mode = 2'($urandom_range(3)); stop2 = 1'($urandom_range(1));
        brk = 1'b1;
        push(w);
`ifdef IS_UART_TX_BREAK_EN
        for (int i = 0; i < 20; i++) begin exp_d.push_back(1'b0); exp_c.push_back(1'b0); end
        exp_d.push_back(1'b1); exp_c.push_back(1'b0);
        if (last_s2) begin exp_d.push_back(1'b1); exp_c.push_back(1'b0); end
`endif
        model_frame(w, par_mode, stop2); model_idle(2);
        for (int i = 0; i < exp_d.size(); i++) begin
`ifdef IS_UART_TX_BREAK_EN
            if (i == 20) brk = 1'b0;
`endif
            tick(2);
        end
        brk = 1'b0;
        for (int i = 0; i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL brk_txd bit %0d got %b exp %b", i, got_d[i], exp_d[i]); end
            checks++; if (got_c[i] !== exp_c[i]) begin errors++; $display("FAIL brk_txct bit %0d got %b exp %b", i, got_c[i], exp_c[i]); end
            checks++; if (got_e[i] !== exp_d[i]) begin errors++; $display("FAIL brk_hold bit %0d got %b exp %b", i, got_e[i], exp_d[i]); end
        end
        $display("break: %0d bit periods with brk_i asserted and word %h queued", exp_d.size(), w);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int n, gap;
            logic [DW-1:0] w;
            clr();
            n = $urandom_range(DEPTH, 1); gap = $urandom_range(6, 2);
            par_mode = 2'($urandom_range(3)); stop2 = 1'($urandom_range(1));
            for (int k = 0; k < n; k++) begin
                w = DW'($urandom);
                push(w);
                model_frame(w, par_mode, stop2);
            end
            model_idle(2);
            for (int i = 0; i < exp_d.size(); i++) tick(gap);
            for (int i = 0; i < got_d.size(); i++) begin
                checks++; if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL rand_txd round %0d bit %0d got %b exp %b", r, i, got_d[i], exp_d[i]); end
                checks++; if (got_c[i] !== exp_c[i]) begin errors++; $display("FAIL rand_txct round %0d bit %0d got %b exp %b", r, i, got_c[i], exp_c[i]); end
                checks++; if (got_e[i] !== exp_d[i]) begin errors++; $display("FAIL rand_hold round %0d bit %0d got %b exp %b", r, i, got_e[i], exp_d[i]); end
            end
            $display("random: round %0d, %0d words, mode %0d stop2 %0d gap %0d", r, n, par_mode, stop2, gap);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_a5();
        test_parity_stop();
        test_fifo_full();
        test_no_bypass();
        test_cfg_change();
        test_reset_mid();
        test_random();
        test_break();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
